// File: rtl/kmc_npr_ctl_if.sv
// KMC NPR bus-side handshake: request/acknowledge, write flag, byte lanes,
// 18-bit address and write data. The controller is the master.
interface kmc_npr_ctl_if;
    logic        devREQO;
    logic        devACKI;
    logic        devWRU;
    logic        devLOBYTE;
    logic        devHIBYTE;
    logic [17:0] devADDRO;
    logic [15:0] devDATAO;

    modport master (
        output devREQO, devWRU, devLOBYTE, devHIBYTE, devADDRO, devDATAO,
        input  devACKI
    );

    modport slave (
        input  devREQO, devWRU, devLOBYTE, devHIBYTE, devADDRO, devDATAO,
        output devACKI
    );
endinterface

// File: rtl/kmc_npr_ctl.sv
// KMC NPR (DMA) transfer controller: latches a microcode-issued transfer,
// requests the bus until acknowledged, then pulses DONE for one cycle.
// Optional bus timeout controlled by macro KMC_NPR_TIMEOUT_EN; when it is
// undefined the request waits indefinitely and kmcNXM is tied to 0.
module kmc_npr_ctl (
    input  logic                clk,
    input  logic                rst,
    input  logic                kmcMCLR,
    input  logic                kmcNPRSTART,
    input  logic                kmcNPRO,
    input  logic                kmcBYTE,
    input  logic [15:0]         kmcNPRIA,
    input  logic [15:0]         kmcNPROA,
    input  logic [15:0]         kmcNPROD,
    input  logic [1:0]          kmcXADDR,
    kmc_npr_ctl_if.master       bus,
    output logic                kmcNPRBUSY,
    output logic                kmcNPRDONE,
    output logic                kmcNXM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state;
    state_t      nstate;

    logic        lat_wr;
    logic        lat_byte;
    logic [1:0]  lat_xaddr;
    logic [15:0] lat_addr;
    logic [15:0] lat_data;

    logic        accept;
    logic        timeout;

    logic        req_o;
    logic        wru_o;
    logic        lo_o;
    logic        hi_o;
    logic [15:0] data_o;

    assign accept = (state == IDLE) && kmcNPRSTART && !kmcMCLR;

`ifdef KMC_NPR_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       nxm_q;

    assign timeout = (state == REQ) && !bus.devACKI && (tmo_cnt == 8'd255);

    // Timeout counter: cleared when a transfer is accepted, counts REQ cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == REQ) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Sticky non-existent-memory flag, cleared only by master clear or reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nxm_q <= 1'b0;
        end else if (kmcMCLR) begin
            nxm_q <= 1'b0;
        end else if (timeout) begin
            nxm_q <= 1'b1;
        end
    end

    assign kmcNXM = nxm_q;
`else
    assign timeout = 1'b0;
    assign kmcNXM  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Transfer parameter latches, loaded when a start is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_wr    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_xaddr <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
        end else if (accept) begin
            lat_wr    <= kmcNPRO;
            lat_byte  <= kmcBYTE;
            lat_xaddr <= kmcXADDR;
            lat_addr  <= kmcNPRO ? kmcNPROA : kmcNPRIA;
            lat_data  <= kmcNPROD;
        end
    end

    // Next-state logic; master clear overrides ACK and start
    always_comb begin
        nstate = state;
        if (kmcMCLR) begin
            nstate = IDLE;
        end else begin
            case (state)
                IDLE: if (kmcNPRSTART) nstate = REQ;
                REQ: begin
                    if (bus.devACKI) begin
                        nstate = DONE;
                    end else if (timeout) begin
                        nstate = ERR;
                    end
                end
                DONE:    nstate = IDLE;
                ERR:     nstate = IDLE;
                default: nstate = IDLE;
            endcase
        end
    end

    // Bus-side outputs: everything except the address is gated by REQ
    always_comb begin
        req_o      = 1'b0;
        wru_o      = 1'b0;
        lo_o       = 1'b0;
        hi_o       = 1'b0;
        data_o     = '0;
        kmcNPRDONE = 1'b0;
        case (state)
            REQ: begin
                req_o  = 1'b1;
                wru_o  = lat_wr;
                lo_o   = !lat_byte || !lat_addr[0];
                hi_o   = !lat_byte ||  lat_addr[0];
                data_o = lat_wr ? lat_data : '0;
            end
            DONE:    kmcNPRDONE = 1'b1;
            default: ;
        endcase
    end

    assign kmcNPRBUSY    = (state != IDLE);
    assign bus.devREQO   = req_o;
    assign bus.devWRU    = wru_o;
    assign bus.devLOBYTE = lo_o;
    assign bus.devHIBYTE = hi_o;
    assign bus.devDATAO  = data_o;
    assign bus.devADDRO  = {lat_xaddr, lat_addr[15:1], lat_addr[0] & lat_byte};

endmodule
